// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequenced one nibble per clock through a single 4-bit adder.
// The carry between nibbles is held in a register; the result is built LSB nibble first.
module nibble_serial_adder_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned W     = 4 * NIBBLES;
  localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned SH_W  = IDX_W + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SH_W-1:0]  nib_sh;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic             last_nib;

  // Shared 4-bit ripple adder slice on the currently selected nibble
  always_comb begin
    nib_sh              = {idx_q, 2'b00};
    nib_a               = 4'(a_q >> nib_sh);
    nib_b               = 4'(b_q >> nib_sh);
    {nib_cout, nib_sum} = 5'(nib_a) + 5'(nib_b) + 5'(carry_q);
    last_nib            = (idx_q == IDX_W'(NIBBLES - 1));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d   = (sum_q & ~(W'(4'hF) << nib_sh)) | (W'(nib_sum) << nib_sh);
        carry_d = nib_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_nib) begin
          cout_d  = nib_cout;
          // b_q is already inverted for subtract, so one rule covers both ops
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (nib_sum[3] != a_q[W-1]);
          idx_d   = '0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl (NIBBLES=4): expected results are
// queued when a request is driven and compared when done pulses.
module tb_nibble_serial_adder_ctrl;

  localparam int unsigned NIB = 4;
  localparam int unsigned W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_cnt = 0;
  exp_t sb_q[$];

  nibble_serial_adder_ctrl #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_sub(op_sub),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: unbounded signed arithmetic decides overflow
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sub, input logic ci);
    exp_t        e;
    logic [W:0]  full;
    int          ta;
    int          tb;
    int          tr;
    ta = int'($signed(av));
    tb = int'($signed(bv));
    if (sub) begin
      full = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
      tr   = ta - tb;
    end else begin
      full = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
      tr   = ta + tb + int'(ci);
    end
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (tr > 32767) || (tr < -32768);
    return e;
  endfunction

  // Output monitor: compares every done pulse against the scoreboard head
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_cnt++;
      check("busy_done_overlap", 32'(busy), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sum",  32'(sum),  32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf",  32'(ovf),  32'(e.ovf));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sub, input logic ci);
    exp_t e;
    e = model(av, bv, sub, ci);
    sb_q.push_back(e);
    @(negedge clk);
    a = av; b = bv; op_sub = sub; cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_c1", 32'(busy), 32'd1);
    for (int i = 2; i <= NIB; i++) begin
      @(negedge clk);
      check("busy_run", 32'(busy), 32'd1);
    end
    @(negedge clk);
    check("done_latency", 32'(done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("sum_held", 32'(sum), 32'(e.sum));
  endtask

  initial begin
    int base;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;

    run_op(16'h1234, 16'h0FCD, 1'b0, 1'b1);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b1, 1'b1);
    run_op(16'hA5C3, 16'h5A3D, 1'b0, 1'b1);

    // start during RUN must be ignored
    base = done_cnt;
    sb_q.push_back(model(16'h0001, 16'h0001, 1'b0, 1'b0));
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("ignore_one_done", 32'(done_cnt - base), 32'd1);

    // start held high: back-to-back ops every NIB+1 cycles
    base = done_cnt;
    for (int k = 0; k < 3; k++) sb_q.push_back(model(16'h0F0F, 16'h00F1, 1'b0, 1'b0));
    a = 16'h0F0F; b = 16'h00F1; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    for (int i = 1; i <= 3 * (NIB + 1); i++) begin
      @(negedge clk);
      check("cont_done_pos", 32'(done), 32'((i % (NIB + 1)) == 0));
      if (i == 3 * (NIB + 1)) start = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("cont_done_cnt", 32'(done_cnt - base), 32'd3);

    // reset in the third RUN cycle abandons the operation
    base = done_cnt;
    a = 16'h1111; b = 16'h0001; op_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_sum",  32'(sum),  32'd0);
    check("midrst_cout", 32'(cout), 32'd0);
    check("midrst_ovf",  32'(ovf),  32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - base), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
